// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: host write port and display scan outputs of seg7_scan_ctrl.
interface seg7_scan_ctrl_if #(parameter int DIGITS = 4);
   localparam int AW = $clog2(DIGITS);
   logic en, wr_en, wr_val, frame_done;
   logic [AW-1:0] wr_addr, scan_idx;
   logic [2:0] wr_data;
   logic [7:0] code;
   logic [DIGITS-1:0] an_n;
   modport master (output en, wr_en, wr_addr, wr_val, wr_data, input code, an_n, scan_idx, frame_done);
   modport slave (input en, wr_en, wr_addr, wr_val, wr_data, output code, an_n, scan_idx, frame_done);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scan with per-digit buffer, slot blanking and frame pulse.
module seg7_scan_ctrl #(
   parameter int DIGITS = 4,
   parameter int PRESCALE = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input logic clk,
   input logic rst_n,
   seg7_scan_ctrl_if.slave bus
);
   localparam int AW = $clog2(DIGITS);
   localparam int CW = $clog2(PRESCALE);
   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [3:0] mem [DIGITS];
   logic [AW-1:0] nxt_idx;
   logic [7:0] lat;
   // The entry for the next slot is read before this edge's write lands, so a same-edge write waits a frame.
   always_comb begin
      nxt_idx = (state == IDLE || bus.scan_idx == AW'(DIGITS - 1)) ? '0 : bus.scan_idx + AW'(1);
      lat = mem[nxt_idx][3] ? 8'b1 << mem[nxt_idx][2:0] : 8'h00;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < DIGITS; i++) mem[i] <= '0;
      else if (bus.wr_en && {1'b0, bus.wr_addr} < (AW + 1)'(DIGITS))
         mem[bus.wr_addr] <= {bus.wr_val, bus.wr_data};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         bus.code <= '0;
         bus.an_n <= '1;
         bus.scan_idx <= '0;
         bus.frame_done <= 1'b0;
      end else if (!bus.en) begin
         state <= IDLE;
         cnt <= '0;
         bus.code <= '0;
         bus.an_n <= '1;
         bus.scan_idx <= '0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.frame_done <= 1'b0;
         case (state)
            IDLE: begin
               state <= BLANK;
               cnt <= '0;
               bus.scan_idx <= '0;
               bus.code <= lat;
            end
            BLANK: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(BLANK_CYCLES - 1)) begin
                  state <= SHOW;
                  bus.an_n <= ~(DIGITS'(1) << bus.scan_idx);
               end
            end
            default:
               if (cnt == CW'(PRESCALE - 1)) begin
                  state <= BLANK;
                  cnt <= '0;
                  bus.an_n <= '1;
                  bus.scan_idx <= nxt_idx;
                  bus.code <= lat;
                  bus.frame_done <= bus.scan_idx == AW'(DIGITS - 1);
               end else
                  cnt <= cnt + CW'(1);
         endcase
      end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: per-cycle scoreboard against a slot/time arithmetic model, plus directed scenario checks.
module tb_seg7_scan_ctrl;
   localparam int D = 4, P = 8, B = 2;
   logic clk = 0, rst_n = 1;
   always #5 clk = ~clk;
   seg7_scan_ctrl_if #(.DIGITS(D)) bus();
   seg7_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct {logic [7:0] code; logic [3:0] an_n; logic [1:0] idx; logic fd;} exp_t;
   exp_t q[$];
   int tests = 0, fails = 0;
   bit m_valid[D];
   int m_val[D];
   bit active;
   int t;
   logic [7:0] lat;
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask
   // Reference: outputs follow from cycles elapsed since enable (slot = t/P, position = t%P).
   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      int dig;
      if (!rst_n) begin
         active = 0;
         t = 0;
         lat = 0;
         for (int i = 0; i < D; i++) begin m_valid[i] = 0; m_val[i] = 0; end
         q.delete();
      end else begin
         if (!bus.en) begin
            active = 0;
            e.code = 8'h00; e.an_n = 4'hf; e.idx = 2'd0; e.fd = 1'b0;
         end else begin
            if (active) t++; else begin active = 1; t = 0; end
            dig = (t / P) % D;
            if (t % P == 0) lat = m_valid[dig] ? 8'(1 << m_val[dig]) : 8'h00;
            e.code = lat;
            e.idx = 2'(dig);
            e.an_n = (t % P >= B) ? ~(4'(1) << dig) : 4'hf;
            e.fd = (t > 0 && t % (D * P) == 0);
         end
         if (bus.wr_en && int'(bus.wr_addr) < D) begin
            m_valid[bus.wr_addr] = bus.wr_val;
            m_val[bus.wr_addr] = int'(bus.wr_data);
         end
         q.push_back(e);
      end
   end
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && q.size() > 0) begin
         e = q.pop_front();
         chk("code", bus.code, e.code);
         chk("an_n", bus.an_n, e.an_n);
         chk("scan_idx", bus.scan_idx, e.idx);
         chk("frame_done", bus.frame_done, e.fd);
      end
   end
   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wr(int a, bit v, int d);
      bus.wr_en = 1; bus.wr_addr = 2'(a); bus.wr_val = v; bus.wr_data = 3'(d);
      tick(1);
      bus.wr_en = 0;
   endtask
   initial begin
      logic [7:0] ctab [4];
      logic [3:0] atab [4];
      ctab = '{8'h08, 8'h20, 8'h01, 8'h80};
      atab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      bus.en = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_val = 0; bus.wr_data = 0;
      #2 rst_n = 0;
      tick(2);
      rst_n = 1;
      tick(2);
      wr(0, 1, 3); wr(1, 1, 5); wr(2, 1, 0); wr(3, 1, 7);
      bus.en = 1;
      tick(1);
      for (int k = 0; k < 4; k++) begin
         tick(4);
         chk("frame_code", bus.code, ctab[k]);
         chk("frame_an", bus.an_n, atab[k]);
         tick(4);
      end
      chk("frame_pulse", bus.frame_done, 1);
      wr(1, 0, 0);
      tick(11);
      chk("blank_code", bus.code, 8'h00);
      chk("blank_an", bus.an_n, 4'b1101);
      tick(3);
      wr(2, 1, 4);
      tick(4);
      chk("hazard_old", bus.code, 8'h01);
      tick(32);
      chk("hazard_new", bus.code, 8'h10);
      bus.en = 0;
      tick(1);
      chk("dis_an", bus.an_n, 4'hf);
      chk("dis_idx", bus.scan_idx, 0);
      chk("dis_code", bus.code, 8'h00);
      bus.en = 1;
      tick(1);
      chk("reen_idx", bus.scan_idx, 0);
      chk("reen_blank0", bus.an_n, 4'hf);
      tick(1);
      chk("reen_blank1", bus.an_n, 4'hf);
      tick(1);
      chk("reen_show", bus.an_n, 4'b1110);
      wr(3, 1, 6);
      tick(23);
      chk("addr3_code", bus.code, 8'h40);
      for (int i = 0; i < 500; i++) begin
         bus.en = ($urandom_range(0, 59) != 0);
         bus.wr_en = $urandom_range(0, 1);
         bus.wr_addr = 2'($urandom_range(0, 3));
         bus.wr_val = $urandom_range(0, 3) != 0;
         bus.wr_data = 3'($urandom_range(0, 7));
         tick(1);
      end
      bus.wr_en = 0;
      bus.en = 0;
      tick(1);
      bus.en = 1;
      tick(4);
      chk("pre_rst_an", bus.an_n, 4'b1110);
      #2 rst_n = 0;
      #1;
      chk("rst_an", bus.an_n, 4'hf);
      chk("rst_code", bus.code, 8'h00);
      chk("rst_idx", bus.scan_idx, 0);
      chk("rst_fd", bus.frame_done, 0);
      bus.en = 0;
      tick(2);
      rst_n = 1;
      tick(3);
      chk("idle_an", bus.an_n, 4'hf);
      chk("idle_code", bus.code, 8'h00);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one one-hot-to-7-segment encoder. It holds a per-digit value buffer written by the host logic and walks through the digits at a prescaled rate. For each digit it drives an 8-bit one-hot code into the shared encoder and enables that digit's anode. A blanking interval at each slot start prevents ghosting between digits.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, range 2..8.
- `PRESCALE`, default 50000: clock cycles per digit slot, at least 2.
- `BLANK_CYCLES`, default 16: cycles at slot start with all anodes off, range 1..PRESCALE-1.
- `clk` in, 1: single clock; all state changes on its rising edge.
- `rst_n` in, 1: reset, asynchronous assert, active-low.
- `en` in, 1: scan enable; low forces IDLE.
- `wr_en` in, 1: buffer write strobe, one write per cycle.
- `wr_addr` in, $clog2(DIGITS): digit index to write. Writes with addresses ≥ DIGITS are ignored.
- `wr_val` in, 1: 1 = digit shows a value; 0 = digit blank.
- `wr_data` in, 3: digit value 0..7.
- `code` out, 8: one-hot code to the encoder inputs {A..H}. Value v is driven as `8'b1 << v`; 0 means blank, and the encoder then outputs all segments off.
- `an_n` out, DIGITS: anode enables, active-low, bit i = digit i.
- `scan_idx` out, $clog2(DIGITS): digit currently owning the encoder.
- `frame_done` out, 1: single-cycle pulse at the end of the last digit's slot.

## Operation
- Buffer: DIGITS entries of {valid, value[2:0]}. A write updates the entry on the clock edge where `wr_en`=1.
- Buffer reads occur only at slot start. The code for a slot is latched into a register when the slot begins. A write to the digit currently displayed therefore takes effect at that digit's next slot.
- States:
  - IDLE: `an_n` all 1, `code`=0, `scan_idx`=0, slot counter 0.
  - BLANK: latched code on `code`, `an_n` all 1.
  - SHOW: latched code on `code`, `an_n` bit `scan_idx` = 0, all other bits 1.
- Transitions:
  - IDLE→BLANK when `en`=1. Digit 0 is selected and its entry is latched.
  - BLANK→SHOW when the slot counter reaches BLANK_CYCLES-1.
  - SHOW→BLANK when the slot counter reaches PRESCALE-1. The counter clears, `scan_idx` advances (DIGITS-1 wraps to 0), and the new digit's entry is latched.
  - Any state→IDLE on the first edge with `en`=0, mid-slot included. The scan restarts at digit 0 when re-enabled.
- Latched code is `8'b1 << value` if valid, else 0.
- `frame_done`=1 for exactly the cycle following the SHOW→BLANK transition out of digit DIGITS-1. It is never asserted in IDLE.
- Simultaneous write and slot start to the same digit: the latched code uses the pre-write buffer contents. The new value is shown one full frame later.
- Reset (`rst_n`=0, at any time): state IDLE, all buffer entries invalid, `an_n` all 1, `code`=0, `scan_idx`=0, `frame_done`=0, slot counter 0.

## Timing
- All outputs are registered.
- Enable latency: `en` sampled high at edge N puts BLANK outputs out after edge N. The first anode goes low after edge N+BLANK_CYCLES.
- Slot length is exactly PRESCALE cycles: BLANK_CYCLES with anodes off, then PRESCALE-BLANK_CYCLES with the anode on.
- Frame length is DIGITS×PRESCALE cycles.
- At most one `an_n` bit is low in any cycle. Zero bits are low during BLANK, IDLE and reset.
- Disable latency is one edge. There are no partial-slot artifacts after `en` falls.

## Test plan
All scenarios use DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
- Reset then idle:
  - Assert `rst_n`=0 mid-SHOW → `an_n`=4'b1111, `code`=0 and `scan_idx`=0 immediately, without waiting for `clk`.
  - Release with `en`=0 → outputs hold those values.
- Full frame:
  - Write digits 0..3 = 3,5,0,7 (all valid), then raise `en`.
  - Required `code` per slot: 0x08, 0x20, 0x01, 0x80.
  - `an_n` = 1110, 1101, 1011, 0111, each low for exactly 6 cycles after 2 blank cycles.
  - `frame_done` pulses once every 32 cycles.
- Blank digit: write digit 1 with `wr_val`=0 → `code`=0 during slot 1. The anode still cycles with normal timing.
- Write hazard: write digit 2 = 4 on the edge where slot 2 begins → that slot shows the old value. Slot 2 of the next frame shows `code`=0x10.
- Mid-slot disable: drop `en` 3 cycles into SHOW of digit 2 → IDLE next edge with `an_n`=1111. Re-enabling restarts at `scan_idx`=0 with a full 2-cycle blank.
- Out-of-range write: writes with `wr_addr` ≥ 4 (possible only when DIGITS < 2^width) → buffer unchanged. With DIGITS=4, check that writing address 3 updates only digit 3.
